servo_pwm_slew: RTL and testbench

Servo pulse generator for the robot arm: accepts target-position commands from the arm controller's key-handling logic and ramps the servo position toward the target at a bounded rate. Emits a standard 50 Hz hobby-servo PWM on `servo_pwm`. Sits directly downstream of the keyboard-command decoding in the arm path, clocked by the pixel clock, and drives the board's servo pin.

---
 rtl/servo_pkg.sv | 28 ++
 rtl/us_tick_gen.sv | 28 ++
 rtl/servo_pwm_slew.sv | 108 ++++++++++
 tb/tb_servo_pwm_slew.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types, default timing and the command-to-target clamp for the servo pulse generator.
package servo_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam int US_W      = 11;
    localparam int FRAME_US  = 20000;
    localparam int MIN_US    = 1000;
    localparam int MAX_US    = 2000;
    localparam int CENTER_US = 1500;

    // 12-bit intermediate so the top code can exceed MAX_US before clamping
    function automatic logic [US_W-1:0] clamp_target(input logic [7:0] code,
                                                     input int min_us,
                                                     input int max_us,
                                                     input int step_us);
        logic [11:0] raw;
        raw = 12'(min_us) + 12'(step_us) * {4'd0, code};
        if (raw > 12'(max_us)) return US_W'(max_us);
        if (raw < 12'(min_us)) return US_W'(min_us);
        return raw[US_W-1:0];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_HZ/1e6-1 while run is high, tick on terminal count.
module us_tick_gen #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick,
    output logic phase_zero
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick       = run && (cnt == TC);
    assign phase_zero = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!run || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/servo_pwm_slew.sv
// 50 Hz servo PWM with frame-aligned position updates; define SERVO_SLEW_EN for the rate-limited ramp.
//  state       | meaning
//  ST_OFF      | counters held at 0, output low
//  ST_RUN      | frames running, position updates at each boundary
//  ST_STOPPING | current frame finishes, then OFF unless enable returns
module servo_pwm_slew #(
    parameter int CLK_HZ    = 25_000_000,
    parameter int FRAME_US  = servo_pkg::FRAME_US,
    parameter int MIN_US    = servo_pkg::MIN_US,
    parameter int MAX_US    = servo_pkg::MAX_US,
    parameter int CENTER_US = servo_pkg::CENTER_US,
    parameter int STEP_US   = 4,
    parameter int SLEW_US   = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cmd_valid,
    input  logic [7:0]                  cmd_target,
    output logic                        servo_pwm,
    output logic                        frame_start,
    output logic                        busy,
    output logic [servo_pkg::US_W-1:0]  pos_us
);
    import servo_pkg::*;

    localparam int FW = $clog2(FRAME_US);
    localparam logic [FW-1:0] FRAME_TC = FW'(FRAME_US - 1);
`ifdef SERVO_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    // Without the ramp, a limit of MAX_US always reaches the target in one step
    localparam int SLEW_LIM = SLEW_EN ? SLEW_US : MAX_US;

    state_t          state, state_nx;
    logic [FW-1:0]   us_cnt;
    logic [US_W-1:0] target, target_nx, pos_step, pos_nx;
    logic            run, tick, phase_zero, wrap, bnd, pwm_nx;

    assign run = (state != ST_OFF);

    us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .tick       (tick),
        .phase_zero (phase_zero)
    );

    // First cycle of a frame in RUN, reached either by a wrap or by OFF->RUN entry
    assign wrap      = tick && (us_cnt == FRAME_TC);
    assign bnd       = (state == ST_RUN) && phase_zero && (us_cnt == '0);
    assign target_nx = cmd_valid ? clamp_target(cmd_target, MIN_US, MAX_US, STEP_US) : target;
    assign pos_nx    = bnd ? pos_step : pos_us;

    always_comb begin
        pos_step = target;
        if (int'(target) > int'(pos_us) + SLEW_LIM)
            pos_step = US_W'(int'(pos_us) + SLEW_LIM);
        else if (int'(target) < int'(pos_us) - SLEW_LIM)
            pos_step = US_W'(int'(pos_us) - SLEW_LIM);
    end

    always_comb begin
        state_nx = state;
        pwm_nx   = 1'b0;
        case (state)
            ST_OFF: begin
                if (enable) state_nx = ST_RUN;
            end
            ST_RUN: begin
                pwm_nx = int'(us_cnt) < int'(pos_nx);
                if (!enable) state_nx = ST_STOPPING;
            end
            ST_STOPPING: begin
                pwm_nx = int'(us_cnt) < int'(pos_nx);
                if (enable)    state_nx = ST_RUN;
                else if (wrap) state_nx = ST_OFF;
            end
            default: state_nx = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_OFF;
            us_cnt      <= '0;
            target      <= US_W'(CENTER_US);
            pos_us      <= US_W'(CENTER_US);
            busy        <= 1'b0;
            servo_pwm   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state <= state_nx;
            if (!run || wrap)
                us_cnt <= '0;
            else if (tick)
                us_cnt <= us_cnt + FW'(1);
            target      <= target_nx;
            pos_us      <= pos_nx;
            busy        <= (pos_nx != target_nx);
            servo_pwm   <= pwm_nx;
            frame_start <= bnd;
        end
    end
endmodule

// File: tb/tb_servo_pwm_slew.sv
// Bench for servo_pwm_slew at scaled timing (3 clocks/us, 300 us frame); follows SERVO_SLEW_EN.
module tb_servo_pwm_slew;
    localparam int CLK_HZ    = 3_000_000;
    localparam int FRAME_US  = 300;
    localparam int MIN_US    = 100;
    localparam int MAX_US    = 160;
    localparam int CENTER_US = 130;
    localparam int STEP_US   = 2;
    localparam int SLEW_US   = 5;
    localparam int DIV       = 3;
    localparam int FRAME_CYC = FRAME_US * DIV;

    logic        clk, reset, enable, cmd_valid;
    logic [7:0]  cmd_target;
    logic        servo_pwm, frame_start, busy;
    logic [10:0] pos_us;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fs = 0;
    bit prev_valid = 0;
    int model_pos, model_target;

    typedef struct { int pos; bit busy; } exp_t;
    exp_t sb[$];

    typedef struct { logic [7:0] code; int exp_target; } vec_t;
    vec_t vecs[6];

    servo_pwm_slew #(
        .CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
        .CENTER_US(CENTER_US), .STEP_US(STEP_US), .SLEW_US(SLEW_US)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
        .cmd_target(cmd_target), .servo_pwm(servo_pwm), .frame_start(frame_start),
        .busy(busy), .pos_us(pos_us)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_step(input int p, input int t);
`ifdef SERVO_SLEW_EN
        if (t > p + SLEW_US) return p + SLEW_US;
        if (t < p - SLEW_US) return p - SLEW_US;
        return t;
`else
        return t;
`endif
    endfunction

    task automatic push(input int p);
        exp_t e;
        e.pos  = p;
        e.busy = (p != model_target);
        sb.push_back(e);
    endtask

    task automatic plan_frames(input int tgt);
        model_target = tgt;
        do begin
            model_pos = model_step(model_pos, model_target);
            push(model_pos);
        end while (model_pos != model_target);
    endtask

    task automatic wait_fs();
        int n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", int'(frame_start), 1);
    endtask

    task automatic check_frame(input int drop_at, input int restore_at);
        exp_t e;
        int hi;
        wait_fs();
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        check("pos_us", int'(pos_us), e.pos);
        check("busy", int'(busy), int'(e.busy));
        if (prev_valid) check("period", cyc - last_fs, FRAME_CYC);
        last_fs    = cyc;
        prev_valid = 1;
        hi = 0;
        while (servo_pwm && hi < FRAME_CYC) begin
            if (hi == drop_at)    enable = 1'b0;
            if (hi == restore_at) enable = 1'b1;
            @(negedge clk);
            hi++;
        end
        check("pulse_width", hi, e.pos * DIV);
        check("pos_hold", int'(pos_us), e.pos);
    endtask

    task automatic drain();
        while (sb.size() != 0) check_frame(-1, -1);
    endtask

    task automatic send_cmd(input logic [7:0] code);
        cmd_target = code;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    initial begin
        int n_fs, n_hi, n;
        vecs[0] = '{8'd15,  130};
        vecs[1] = '{8'd30,  160};
        vecs[2] = '{8'd255, 160};
        vecs[3] = '{8'd31,  160};
        vecs[4] = '{8'd0,   100};
        vecs[5] = '{8'd3,   106};

        reset = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_target = 8'd0;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_pwm", int'(servo_pwm), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pos_us", int'(pos_us), CENTER_US);
        reset = 1'b0;
        model_pos = CENTER_US;
        model_target = CENTER_US;

        n_fs = 0; n_hi = 0;
        repeat (60) begin
            @(negedge clk);
            n_fs += int'(frame_start);
            n_hi += int'(servo_pwm);
        end
        check("off_no_frame", n_fs, 0);
        check("off_no_pwm", n_hi, 0);

        enable = 1'b1;
        @(negedge clk);
        check("entry_fs_delay", int'(frame_start), 0);
        check("entry_pwm_delay", int'(servo_pwm), 0);
        @(negedge clk);
        check("entry_fs", int'(frame_start), 1);
        check("entry_pwm", int'(servo_pwm), 1);
        plan_frames(CENTER_US);
        drain();

        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i].code);
            check("busy_after_cmd", int'(busy), int'(vecs[i].exp_target != model_pos));
            plan_frames(vecs[i].exp_target);
            drain();
        end

        send_cmd(8'd30);
        send_cmd(8'd0);
        check("last_cmd_busy", int'(busy), int'(model_pos != 100));
        plan_frames(100);
        drain();

        plan_frames(100);
        check_frame(-1, -1);
        n = 0;
        while (cyc != last_fs + FRAME_CYC - 1 && n < FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check("align_cycle", cyc - last_fs, FRAME_CYC - 1);
        cmd_target = 8'd3;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        check("coincide_fs", int'(frame_start), 1);
        model_pos = model_step(model_pos, model_target);
        model_target = 106;
        push(model_pos);
        plan_frames(106);
        drain();

        plan_frames(106);
        check_frame(20, -1);
        n_fs = 0; n_hi = 0;
        repeat (2 * FRAME_CYC) begin
            @(negedge clk);
            n_fs += int'(frame_start);
            n_hi += int'(servo_pwm);
        end
        check("stop_no_frame", n_fs, 0);
        check("stop_no_pwm", n_hi, 0);
        prev_valid = 0;
        enable = 1'b1;
        plan_frames(106);
        check_frame(-1, -1);

        plan_frames(106);
        check_frame(20, 40);
        plan_frames(106);
        check_frame(-1, -1);

        wait_fs();
        repeat (10) @(negedge clk);
        check("pwm_before_reset", int'(servo_pwm), 1);
        reset = 1'b1;
        #1;
        check("reset_pwm_async", int'(servo_pwm), 0);
        check("reset_pos_us", int'(pos_us), CENTER_US);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        prev_valid = 0;
        model_pos = CENTER_US;
        model_target = CENTER_US;
        plan_frames(CENTER_US);
        drain();
        send_cmd(8'd0);
        check("busy_to_min", int'(busy), 1);
        plan_frames(MIN_US);
        drain();
        send_cmd(8'd30);
        check("busy_to_max", int'(busy), 1);
        plan_frames(MAX_US);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
